nmr_scan_sequencer: RTL and testbench

Multi-scan controller sitting directly above the NMR pulse program engine. It runs a programmed number of CPMG/T1 scans back to back and handshakes each scan's START/FSMSTAT with the engine. Between scans it inserts a programmable recovery delay and drives the per-scan PHASE_CYC input for phase cycling. Host logic issues one RUN pulse and receives one DONE pulse.

---
 rtl/nmr_pkg.sv | 17 +
 rtl/nmr_delay_counter.sv | 28 ++
 rtl/nmr_scan_sequencer.sv | 160 ++++++++++++++++
 tb/tb_nmr_scan_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_pkg.sv
// Shared definitions for the NMR multi-scan sequencer: one-hot state
// encoding and default widths.
package nmr_pkg;

  localparam int SCAN_CNT_WIDTH = 16;
  localparam int DELAY_WIDTH    = 32;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    ARM      = 6'b000010,
    WAIT_END = 6'b000100,
    RECOVER  = 6'b001000,
    NEXT     = 6'b010000,
    FINISH   = 6'b100000
  } state_t;

endpackage

// File: rtl/nmr_delay_counter.sv
// Loadable down-counter timing the inter-scan recovery gap; TC flags the
// last counted cycle so the caller leaves after exactly LOAD_VAL enables.
module nmr_delay_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             EN,
  output logic             TC
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VAL;
    end else if (EN && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign TC = (count == WIDTH'(1));

endmodule

// File: rtl/nmr_scan_sequencer.sv
// Runs NUM_SCANS pulse-program scans back to back with a recovery gap.
// Define NMR_SCAN_PHCYC_EN to alternate PHASE_CYC per scan; otherwise it stays 0.
module nmr_scan_sequencer #(
  parameter int SCAN_CNT_WIDTH = nmr_pkg::SCAN_CNT_WIDTH,
  parameter int DELAY_WIDTH    = nmr_pkg::DELAY_WIDTH,
  parameter int START_TIMEOUT  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      RUN,
  input  logic                      ABORT,
  input  logic [SCAN_CNT_WIDTH-1:0] NUM_SCANS,
  input  logic [DELAY_WIDTH-1:0]    SCAN_DELAY,
  input  logic                      PP_FSMSTAT,
  output logic                      PP_START,
  output logic                      PHASE_CYC,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ABORTED,
  output logic                      TIMEOUT_ERR,
  output logic [SCAN_CNT_WIDTH-1:0] SCAN_IDX
);

  import nmr_pkg::*;

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [SCAN_CNT_WIDTH-1:0] IDX_ONE = SCAN_CNT_WIDTH'(1);

  state_t                    state;
  logic [SCAN_CNT_WIDTH-1:0] num_l;
  logic [DELAY_WIDTH-1:0]    delay_l;
  logic [TW-1:0]             arm_cnt;
  logic                      abort_pend;
  logic                      abort_any;
  logic                      dly_load;
  logic                      dly_en;
  logic                      dly_tc;

  // An ABORT arriving this very cycle acts like one already pending.
  assign abort_any = ABORT || abort_pend;

  always_comb begin
    dly_load = 1'b0;
    dly_en   = 1'b0;
    if ((state == WAIT_END) && !PP_FSMSTAT && (delay_l != '0) && !abort_any)
      dly_load = 1'b1;
    if (state == RECOVER)
      dly_en = 1'b1;
  end

  nmr_delay_counter #(
    .WIDTH (DELAY_WIDTH)
  ) u_delay (
    .CLK      (CLK),
    .RESET    (RESET),
    .LOAD     (dly_load),
    .LOAD_VAL (delay_l),
    .EN       (dly_en),
    .TC       (dly_tc)
  );

  // NOTE: all state and outputs are updated with <= so every read in this
  // block sees the pre-edge value, exactly like the flops it describes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      num_l       <= '0;
      delay_l     <= '0;
      arm_cnt     <= '0;
      abort_pend  <= 1'b0;
      PP_START    <= 1'b0;
      PHASE_CYC   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ABORTED     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      SCAN_IDX    <= '0;
    end else begin
      DONE <= 1'b0;
      if ((state != IDLE) && ABORT)
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          // DONE still high means the series just ended; that RUN is dropped.
          if (RUN && !DONE) begin
            num_l       <= NUM_SCANS;
            delay_l     <= SCAN_DELAY;
            SCAN_IDX    <= '0;
            ABORTED     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            PHASE_CYC   <= 1'b0;
            abort_pend  <= 1'b0;
            arm_cnt     <= '0;
            BUSY        <= 1'b1;
            if (NUM_SCANS == '0) begin
              state <= FINISH;
            end else begin
              PP_START <= 1'b1;
              state    <= ARM;
            end
          end
        end

        ARM: begin
          // Once the engine reports busy it cannot be stopped, so abort waits.
          if (PP_FSMSTAT) begin
            PP_START <= 1'b0;
            state    <= WAIT_END;
          end else if (abort_any) begin
            PP_START <= 1'b0;
            state    <= FINISH;
          end else if (arm_cnt == TW'(START_TIMEOUT - 1)) begin
            PP_START    <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            state       <= FINISH;
          end else begin
            arm_cnt <= arm_cnt + TW'(1);
          end
        end

        WAIT_END: begin
          if (!PP_FSMSTAT)
            state <= ((delay_l == '0) || abort_any) ? NEXT : RECOVER;
        end

        RECOVER: begin
          if (abort_any)
            state <= FINISH;
          else if (dly_tc)
            state <= NEXT;
        end

        NEXT: begin
          if (abort_any || (SCAN_IDX == num_l - IDX_ONE)) begin
            state <= FINISH;
          end else begin
            SCAN_IDX <= SCAN_IDX + IDX_ONE;
`ifdef NMR_SCAN_PHCYC_EN
            PHASE_CYC <= ~PHASE_CYC;
`endif
            arm_cnt  <= '0;
            PP_START <= 1'b1;
            state    <= ARM;
          end
        end

        FINISH: begin
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          ABORTED <= abort_pend;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// Self-checking bench for nmr_scan_sequencer with a behavioural engine model;
// expectations come from scan-timing arithmetic on recorded event times.
module tb_nmr_scan_sequencer;

  localparam int SW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          RUN = 1'b0;
  logic          ABORT = 1'b0;
  logic [SW-1:0] NUM_SCANS = '0;
  logic [DW-1:0] SCAN_DELAY = '0;
  logic          PP_FSMSTAT = 1'b0;
  logic          PP_START;
  logic          PHASE_CYC;
  logic          BUSY;
  logic          DONE;
  logic          ABORTED;
  logic          TIMEOUT_ERR;
  logic [SW-1:0] SCAN_IDX;

  nmr_scan_sequencer #(
    .SCAN_CNT_WIDTH (SW),
    .DELAY_WIDTH    (DW),
    .START_TIMEOUT  (TO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RUN         (RUN),
    .ABORT       (ABORT),
    .NUM_SCANS   (NUM_SCANS),
    .SCAN_DELAY  (SCAN_DELAY),
    .PP_FSMSTAT  (PP_FSMSTAT),
    .PP_START    (PP_START),
    .PHASE_CYC   (PHASE_CYC),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ABORTED     (ABORTED),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .SCAN_IDX    (SCAN_IDX)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run_c = 0;

  always @(posedge CLK) cyc++;

  // Engine: sees START at an edge, raises FSMSTAT one edge later for eng_hi cycles.
  int   eng_hi    = 50;
  bit   eng_never = 1'b0;
  int   eph       = 0;
  int   ecnt      = 0;
  logic st_s;

  always @(posedge CLK) begin
    st_s = PP_START;
    #1;
    if (RESET) begin
      eph        = 0;
      PP_FSMSTAT = 1'b0;
    end else begin
      case (eph)
        0: if (st_s && !eng_never) eph = 1;
        1: begin
          PP_FSMSTAT = 1'b1;
          ecnt       = eng_hi;
          eph        = 2;
        end
        default: begin
          ecnt--;
          if (ecnt == 0) begin
            PP_FSMSTAT = 1'b0;
            eph        = 0;
          end
        end
      endcase
    end
  end

  // Event recorder sampled on the falling edge.
  int   rise_t[$], rise_idx[$], rise_ph[$], fall_t[$], hi_len[$];
  int   done_t[$], done_ab[$], done_to[$], done_idx[$];
  int   busy_cnt = 0, ph_viol = 0, run_len = 0;
  logic p_start = 1'b0, p_fsm = 1'b0, p_phase = 1'b0;

  always @(negedge CLK) begin
    if (PP_START && !p_start) begin
      rise_t.push_back(cyc);
      rise_idx.push_back(int'(SCAN_IDX));
      rise_ph.push_back(int'(PHASE_CYC));
    end
    if (PP_START) run_len++;
    else if (p_start) begin
      hi_len.push_back(run_len);
      run_len = 0;
    end
    if (!PP_FSMSTAT && p_fsm) fall_t.push_back(cyc);
    if (DONE) begin
      done_t.push_back(cyc);
      done_ab.push_back(int'(ABORTED));
      done_to.push_back(int'(TIMEOUT_ERR));
      done_idx.push_back(int'(SCAN_IDX));
    end
    if (BUSY) busy_cnt++;
    if (PP_FSMSTAT && p_fsm && (PHASE_CYC != p_phase)) ph_viol++;
    p_start = PP_START;
    p_fsm   = PP_FSMSTAT;
    p_phase = PHASE_CYC;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_phase(input int i);
`ifdef NMR_SCAN_PHCYC_EN
    return i % 2;
`else
    return 0 * i;
`endif
  endfunction

  task automatic clear_mon();
    rise_t.delete(); rise_idx.delete(); rise_ph.delete(); fall_t.delete();
    hi_len.delete(); done_t.delete(); done_ab.delete(); done_to.delete();
    done_idx.delete();
    busy_cnt = 0;
    ph_viol  = 0;
  endtask

  task automatic do_run(input int n, input int d);
    @(negedge CLK);
    NUM_SCANS  = SW'(n);
    SCAN_DELAY = DW'(d);
    RUN        = 1'b1;
    run_c      = cyc;
    @(negedge CLK);
    RUN        = 1'b0;
    NUM_SCANS  = SW'($urandom);
    SCAN_DELAY = DW'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (DONE !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_done_seen"}, int'(DONE), 1);
  endtask

  task automatic check_series(input int n, input int d, input string tag);
    check({tag, "_starts"}, rise_t.size(), n);
    if (rise_t.size() > 0) check({tag, "_first_start"}, rise_t[0] - run_c, 1);
    for (int i = 0; i < n && i < rise_t.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), rise_idx[i], i);
      check($sformatf("%s_phase%0d", tag, i), rise_ph[i], exp_phase(i));
      if (i > 0 && fall_t.size() >= i)
        check($sformatf("%s_gap%0d", tag, i), rise_t[i] - fall_t[i-1], d + 2);
    end
    check({tag, "_done_cnt"}, done_t.size(), 1);
    if (done_t.size() > 0) begin
      if (fall_t.size() >= n)
        check({tag, "_done_time"}, done_t[0] - fall_t[n-1], d + 3);
      check({tag, "_aborted"}, done_ab[0], 0);
      check({tag, "_timeout"}, done_to[0], 0);
      check({tag, "_done_idx"}, done_idx[0], n - 1);
      check({tag, "_busy_len"}, busy_cnt, done_t[0] - run_c - 1);
    end
    check({tag, "_phase_stable"}, ph_viol, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, k;

    // Reset values
    repeat (3) @(negedge CLK);
    check("reset_outs", int'({PP_START, PHASE_CYC, BUSY, DONE, ABORTED, TIMEOUT_ERR, SCAN_IDX}), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Three scans, delay 10, with a RUN while busy and one coincident with DONE
    eng_hi = 50;
    clear_mon();
    do_run(3, 10);
    check("main_busy_t1", int'(BUSY), 1);
    check("main_start_t1", int'(PP_START), 1);
    repeat (20) @(negedge CLK);
    NUM_SCANS = SW'(9);
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    wait_done(600, "main");
    NUM_SCANS = SW'(2);
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    repeat (6) @(negedge CLK);
    check_series(3, 10, "main");
    check("main_idle_after", int'(BUSY), 0);

    // Randomized series
    for (int r = 0; r < 3; r++) begin
      n      = $urandom_range(1, 4);
      d      = $urandom_range(0, 15);
      eng_hi = $urandom_range(2, 20);
      clear_mon();
      do_run(n, d);
      wait_done(n * (eng_hi + d + 12) + 40, $sformatf("rnd%0d", r));
      repeat (4) @(negedge CLK);
      check_series(n, d, $sformatf("rnd%0d", r));
    end

    // NUM_SCANS == 0
    clear_mon();
    do_run(0, 5);
    wait_done(10, "zero");
    repeat (4) @(negedge CLK);
    check("zero_starts", rise_t.size(), 0);
    check("zero_done_cnt", done_t.size(), 1);
    if (done_t.size() > 0) check("zero_done_time", done_t[0] - run_c, 2);
    check("zero_busy_len", busy_cnt, 1);

    // Zero recovery delay
    eng_hi = 12;
    clear_mon();
    do_run(2, 0);
    wait_done(200, "d0");
    repeat (4) @(negedge CLK);
    check_series(2, 0, "d0");

    // Engine never starts
    eng_never = 1'b1;
    clear_mon();
    do_run(3, 5);
    wait_done(60, "tmo");
    repeat (4) @(negedge CLK);
    check("tmo_starts", rise_t.size(), 1);
    if (hi_len.size() > 0) check("tmo_high_len", hi_len[0], TO);
    check("tmo_done_cnt", done_t.size(), 1);
    if (done_t.size() > 0 && rise_t.size() > 0) begin
      check("tmo_flag", done_to[0], 1);
      check("tmo_idx", done_idx[0], 0);
      check("tmo_aborted", done_ab[0], 0);
      check("tmo_done_time", done_t[0] - rise_t[0], TO + 1);
    end
    eng_never = 1'b0;

    // Abort during WAIT_END of scan 1 of 5
    eng_hi = 30;
    clear_mon();
    do_run(5, 4);
    k = 0;
    while (!(SCAN_IDX == SW'(1) && PP_FSMSTAT) && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check("abort_reached_scan1", int'(SCAN_IDX), 1);
    repeat (5) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    wait_done(200, "abort");
    repeat (8) @(negedge CLK);
    check("abort_starts", rise_t.size(), 2);
    check("abort_done_cnt", done_t.size(), 1);
    if (done_t.size() > 0) begin
      check("abort_flag", done_ab[0], 1);
      check("abort_idx", done_idx[0], 1);
      check("abort_timeout", done_to[0], 0);
      if (fall_t.size() >= 2) check("abort_done_time", done_t[0] - fall_t[1], 3);
    end

    // Reset during RECOVER of scan 2, then restart
    eng_hi = 10;
    clear_mon();
    do_run(4, 20);
    k = 0;
    while (fall_t.size() < 3 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    repeat (3) @(negedge CLK);
    check("rst_pre_idx", int'(SCAN_IDX), 2);
    check("rst_pre_busy", int'(BUSY), 1);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_async_outs", int'({PP_START, PHASE_CYC, BUSY, DONE, ABORTED, TIMEOUT_ERR, SCAN_IDX}), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    eng_hi = 8;
    clear_mon();
    do_run(2, 3);
    wait_done(100, "after_rst");
    repeat (4) @(negedge CLK);
    check_series(2, 3, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
